// File: rtl/common.sv
// Shared posit definitions for the add-path back end: word constants, scale limits and packer states.
package common;

    typedef enum logic {
        SIGN_POS = 1'b0,
        SIGN_NEG = 1'b1
    } sign_t;

    localparam int POSIT_W  = 8;
    localparam int POSIT_ES = 1;

    localparam logic [POSIT_W-1:0] POSIT_ZERO   = 8'h00;
    localparam logic [POSIT_W-1:0] POSIT_NAR    = 8'h80;
    localparam logic [POSIT_W-1:0] POSIT_MAXPOS = 8'h7F;
    localparam logic [POSIT_W-1:0] POSIT_MINPOS = 8'h01;

    // Internal scale is wide enough that (k << ES) + e minus seven normalisation steps never wraps.
    localparam int SCALE_W = 10;
    localparam logic signed [SCALE_W-1:0] SCALE_SAT_HI = 10'((POSIT_W - 2) << POSIT_ES);
    localparam logic signed [SCALE_W-1:0] SCALE_SAT_LO = -SCALE_SAT_HI;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        PACK = 2'd2,
        HOLD = 2'd3
    } packer_state_t;

endpackage

// File: rtl/posit_field_encoder.sv
// Turns a normalised (scale, fraction) pair into the unsigned rounded posit magnitude word,
// saturating to minpos/maxpos. Built for an 8-bit posit with a 1-bit exponent field.
module posit_field_encoder
    import common::*;
(
    input  logic signed [SCALE_W-1:0] scale,
    input  logic [6:0]                frac,
    output logic [POSIT_W-1:0]        magnitude
);

    logic signed [SCALE_W-1:0] regime;
    logic [SCALE_W-1:0]        run_len;
    logic [23:0]               bits;
    logic [6:0]                word;
    logic                      guard;
    logic                      sticky;
    logic                      round_up;
    logic [7:0]                rounded;

    // Left-align regime, exponent and fraction in a wide field, then keep the top seven bits;
    // everything below the guard bit feeds the sticky so dropped exponent bits round too.
    always_comb begin
        regime  = scale >>> POSIT_ES;
        run_len = regime[SCALE_W-1] ? 10'(-regime) : 10'(regime + 10'sd1);
        if (regime[SCALE_W-1]) begin
            bits = {1'b1, scale[0], frac, 15'b0} >> run_len;
        end else begin
            bits = ~(24'hFF_FFFF >> run_len) | ({1'b0, scale[0], frac, 15'b0} >> run_len);
        end
        word     = bits[23:17];
        guard    = bits[16];
        sticky   = |bits[15:0];
        round_up = guard & (sticky | word[0]);
        rounded  = {1'b0, word} + {7'b0, round_up};

        if (scale >= SCALE_SAT_HI) begin
            magnitude = POSIT_MAXPOS;
        end else if (scale < SCALE_SAT_LO) begin
            magnitude = POSIT_MINPOS;
        end else if (rounded == POSIT_NAR) begin
            magnitude = POSIT_MAXPOS;
        end else if (rounded == POSIT_ZERO) begin
            magnitude = POSIT_MINPOS;
        end else begin
            magnitude = rounded;
        end
    end

endmodule

// File: rtl/posit_result_packer.sv
// Posit add-path back end: normalises the interim mantissa one bit per cycle, then encodes,
// rounds, saturates and optionally negates into the final packed posit word.
module posit_result_packer
    import common::*;
#(
    parameter int WIDTH = POSIT_W,
    parameter int ES    = POSIT_ES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       mantissa_sum,
    input  logic [7:0]       interim_regime,
    input  logic [7:0]       interim_exponent,
    input  logic             negate_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_posit
);

    packer_state_t             state_q;
    logic [7:0]                m_q;
    logic signed [SCALE_W-1:0] scale_q;
    sign_t                     neg_q;

    logic signed [SCALE_W-1:0] regime_ext;
    logic signed [SCALE_W-1:0] exponent_ext;
    logic signed [SCALE_W-1:0] scale_in;
    logic [POSIT_W-1:0]        magnitude;
    logic [WIDTH-1:0]          packed_word;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);

    assign regime_ext   = {{2{interim_regime[7]}}, interim_regime};
    assign exponent_ext = {{2{interim_exponent[7]}}, interim_exponent};
    assign scale_in     = (regime_ext <<< ES) + exponent_ext;

    posit_field_encoder u_encoder (
        .scale     (scale_q),
        .frac      (m_q[6:0]),
        .magnitude (magnitude)
    );

    // Zero mantissa always packs to zero; the magnitude is never 0x80, so negation cannot reach NaR.
    always_comb begin
        packed_word = POSIT_ZERO;
        if (m_q != 8'd0) begin
            packed_word = (neg_q == SIGN_NEG) ? (~magnitude + 8'd1) : magnitude;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            m_q       <= 8'd0;
            scale_q   <= '0;
            neg_q     <= SIGN_POS;
            out_posit <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        m_q     <= mantissa_sum;
                        scale_q <= scale_in;
                        neg_q   <= sign_t'(negate_result);
                        state_q <= NORM;
                    end
                end
                NORM: begin
                    if (m_q == 8'd0) begin
                        state_q <= PACK;
                    end else if (!m_q[7]) begin
                        m_q     <= {m_q[6:0], 1'b0};
                        scale_q <= scale_q - 10'sd1;
                    end else begin
                        state_q <= PACK;
                    end
                end
                PACK: begin
                    out_posit <= packed_word;
                    state_q   <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_posit_result_packer.sv
// Scoreboard bench for posit_result_packer: a bit-string reference model predicts each word and
// its latency; a monitor pops and checks whenever the packer presents a result.
module tb_posit_result_packer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] mantissa_sum = 8'd0;
    logic [7:0] interim_regime = 8'd0;
    logic [7:0] interim_exponent = 8'd0;
    logic       negate_result = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_posit;

    int tests_run = 0;
    int tests_failed = 0;
    int cycle = 0;

    typedef struct {
        int posit;
        int lat;
        int accept;
        int hold;
    } exp_t;

    exp_t sb[$];

    posit_result_packer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .mantissa_sum     (mantissa_sum),
        .interim_regime   (interim_regime),
        .interim_exponent (interim_exponent),
        .negate_result    (negate_result),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_posit        (out_posit)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual,
                     expected, expected);
        end
    endtask

    // Reference: value = m/128 * 2^(2k+ex); write the posit as a list of bits and round that list.
    function automatic void model(input int m_in, input int k, input int ex,
                                  input int neg, output int posit, output int lat);
        int m, e_scale, e_bit, kk, frac, word, mag;
        bit q[$];
        bit sticky;
        m = m_in;
        lat = 2;
        if (m == 0) begin
            posit = 0;
            return;
        end
        e_scale = 2 * k + ex;
        while (m < 128) begin
            m = m * 2;
            e_scale = e_scale - 1;
            lat++;
        end
        if (e_scale >= 12) begin
            mag = 127;
        end else if (e_scale < -12) begin
            mag = 1;
        end else begin
            e_bit = ((e_scale % 2) + 2) % 2;
            kk = (e_scale - e_bit) / 2;
            if (kk >= 0) begin
                repeat (kk + 1) q.push_back(1'b1);
                q.push_back(1'b0);
            end else begin
                repeat (-kk) q.push_back(1'b0);
                q.push_back(1'b1);
            end
            q.push_back(e_bit[0]);
            frac = m - 128;
            for (int i = 6; i >= 0; i--) q.push_back(((frac >> i) & 1) != 0);
            word = 0;
            for (int i = 0; i < 7; i++) word = word * 2 + int'(q[i]);
            sticky = 1'b0;
            for (int i = 8; i < q.size(); i++) sticky = sticky | q[i];
            if (q[7] && (sticky || (word % 2 == 1))) word++;
            if (word >= 128) word = 127;
            if (word == 0) word = 1;
            mag = word;
        end
        posit = (neg != 0) ? (256 - mag) % 256 : mag;
    endfunction

    // Called at a falling edge; optionally shows junk while the packer is busy, then waits for
    // in_ready, presents the operation and records what the monitor should see.
    task automatic applyStimulus(input int m, input int k, input int ex, input int neg,
                                 input int hold, input int garbage, input int fixed_exp);
        int waited;
        int mdl_posit, mdl_lat;
        exp_t it;
        waited = 0;
        if (garbage != 0) begin
            in_valid         = 1'b1;
            mantissa_sum     = 8'($urandom);
            interim_regime   = 8'($urandom);
            interim_exponent = 8'($urandom);
            negate_result    = 1'($urandom);
        end
        while (in_ready !== 1'b1) begin
            if (waited >= 200) begin
                checkOutput("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            waited++;
        end
        model(m, k, ex, neg, mdl_posit, mdl_lat);
        it.posit  = (fixed_exp >= 0) ? fixed_exp : mdl_posit;
        it.lat    = mdl_lat;
        it.accept = cycle + 1;
        it.hold   = hold;
        sb.push_back(it);
        in_valid         = 1'b1;
        mantissa_sum     = 8'(m);
        interim_regime   = 8'(k);
        interim_exponent = 8'(ex);
        negate_result    = (neg != 0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic resetMidOp();
        int waited;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        in_valid         = 1'b1;
        mantissa_sum     = 8'h01;
        interim_regime   = 8'd0;
        interim_exponent = 8'd0;
        negate_result    = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_out_valid", int'(out_valid), 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_in_ready", int'(in_ready), 1);
        checkOutput("abort_out_valid_after", int'(out_valid), 0);
    endtask

    // Monitor: first cycle of each presentation pops and checks; later cycles check stability.
    initial begin
        bit   presenting;
        int   wait_cnt;
        int   hold_target;
        int   held;
        exp_t it;
        presenting  = 1'b0;
        wait_cnt    = 0;
        hold_target = 0;
        held        = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                presenting = 1'b0;
                out_ready  = 1'b0;
            end else if (out_valid) begin
                if (!presenting) begin
                    presenting = 1'b1;
                    wait_cnt   = 0;
                    held       = int'(out_posit);
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_output", int'(out_posit), -1);
                        hold_target = 0;
                    end else begin
                        it = sb.pop_front();
                        checkOutput("posit", int'(out_posit), it.posit);
                        checkOutput("latency", cycle - it.accept, it.lat);
                        hold_target = it.hold;
                    end
                end else begin
                    wait_cnt++;
                    checkOutput("hold_stable", int'(out_posit), held);
                    checkOutput("busy_in_ready", int'(in_ready), 0);
                end
                out_ready = (wait_cnt >= hold_target);
            end else begin
                presenting = 1'b0;
                out_ready  = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        int m, k, ex;
        repeat (3) @(negedge clk);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_out_posit", int'(out_posit), 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_in_ready", int'(in_ready), 1);

        applyStimulus(8'h80, 0, 0, 0, 0, 0, 8'h40);
        applyStimulus(8'h20, 0, 0, 0, 0, 0, 8'h20);
        applyStimulus(8'hC0, 0, 0, 0, 5, 0, 8'h48);
        applyStimulus(8'h80, 0, 0, 1, 0, 1, 8'hC0);
        applyStimulus(8'h84, 0, 0, 0, 0, 0, 8'h40);
        applyStimulus(8'h8C, 0, 0, 0, 2, 0, 8'h42);
        applyStimulus(8'h80, 7, 0, 0, 0, 0, 8'h7F);
        applyStimulus(8'h80, -7, 0, 0, 0, 0, 8'h01);
        applyStimulus(8'h80, -7, 0, 1, 0, 0, 8'hFF);
        applyStimulus(8'h00, 0, 0, 1, 0, 0, 8'h00);

        resetMidOp();
        applyStimulus(8'h01, 1, 1, 0, 0, 0, -1);

        for (int i = 0; i < 300; i++) begin
            m  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
            if ($urandom_range(0, 7) == 0) begin
                k  = int'($urandom_range(0, 255)) - 128;
                ex = int'($urandom_range(0, 255)) - 128;
            end else begin
                k  = int'($urandom_range(0, 14)) - 7;
                ex = int'($urandom_range(0, 4)) - 2;
            end
            applyStimulus(m, k, ex, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 1)), -1);
        end

        waited = 0;
        while ((sb.size() != 0 || out_valid) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("drain_pending", sb.size(), 0);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
